// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_reader
// Brief    : Reads a byte range from SPI NOR flash (mode 0) and streams it out
//            as 8-bit AXI-Stream. Define SPI_FLASH_READER_FAST_READ_EN to use
//            FAST_READ (0x0B plus 8 dummy clocks) instead of READ (0x03).
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_reader #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        sresetn,
    output logic        s_cmd_tready,
    input  logic        s_cmd_tvalid,
    input  logic [23:0] s_cmd_addr,
    input  logic [15:0] s_cmd_len,
    input  logic        m_axis_tready,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    output logic        busy,
    output logic        spi_csn,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

`ifdef SPI_FLASH_READER_FAST_READ_EN
    localparam logic [7:0] C_OPCODE   = 8'h0B;
    localparam int         C_CMD_BITS = 40;
`else
    localparam logic [7:0] C_OPCODE   = 8'h03;
    localparam int         C_CMD_BITS = 32;
`endif

    localparam int              C_CW         = $clog2(2 * CLK_DIV + 1) + 1;
    localparam logic [C_CW-1:0] C_DIV_LAST   = C_CW'(CLK_DIV - 1);
    localparam logic [C_CW-1:0] C_SETUP_LAST = C_CW'(CLK_DIV);
    localparam logic [C_CW-1:0] C_HOLD_LAST  = C_CW'(2 * CLK_DIV - 1);
    localparam logic [5:0]      C_BIT_LAST   = 6'(C_CMD_BITS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CS_SETUP = 3'd1;
    localparam logic [2:0] S_CMD      = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_CS_HOLD  = 3'd5;

    logic [2:0]            r_state;
    logic [C_CW-1:0]       r_cnt;
    logic [5:0]            r_bit;
    logic [2:0]            r_dbit;
    logic [C_CMD_BITS-1:0] r_shift;
    logic [6:0]            r_rx;
    logic [15:0]           r_remaining;
    logic                  r_tready;
    logic                  r_busy;
    logic                  r_csn;
    logic                  r_sck;
    logic                  r_mosi;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [7:0]            r_tdata;

    logic                  w_tick;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_out_free;
    logic                  w_cmd_hs;
    logic                  w_load;
    logic [C_CMD_BITS-1:0] w_cmd_word;

    // One divider serves both SCK phases: a tick toggles SCK.
    assign w_tick     = (r_cnt == C_DIV_LAST);
    assign w_rise     = w_tick && !r_sck;
    assign w_fall     = w_tick && r_sck;
    assign w_out_free = !r_tvalid || m_axis_tready;
    assign w_cmd_hs   = r_tready && s_cmd_tvalid;
    assign w_load     = (r_state == S_DATA) && w_rise && (r_dbit == 3'd7);
    // Opcode and address left-aligned; any dummy bits trail as zeros.
    assign w_cmd_word = C_CMD_BITS'({C_OPCODE, s_cmd_addr}) << (C_CMD_BITS - 32);

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_dbit      <= '0;
            r_shift     <= '0;
            r_rx        <= '0;
            r_remaining <= '0;
            r_tready    <= 1'b0;
            r_busy      <= 1'b0;
            r_csn       <= 1'b1;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tready <= 1'b1;
                    r_cnt    <= '0;
                    if (w_cmd_hs && (s_cmd_len != 16'd0)) begin
                        r_tready    <= 1'b0;
                        r_busy      <= 1'b1;
                        r_remaining <= s_cmd_len;
                        r_shift     <= w_cmd_word;
                        r_state     <= S_CS_SETUP;
                    end
                end

                S_CS_SETUP: begin
                    r_csn  <= 1'b0;
                    r_mosi <= r_shift[C_CMD_BITS-1];
                    // Count includes the cycle that drops CSN, so SCK rises CLK_DIV later.
                    if (r_cnt == C_SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_sck   <= 1'b1;
                        r_bit   <= '0;
                        r_state <= S_CMD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_CMD: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        r_sck <= !r_sck;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_fall) begin
                        if (r_bit == C_BIT_LAST) begin
                            r_mosi  <= 1'b0;
                            r_dbit  <= '0;
                            r_state <= S_DATA;
                        end else begin
                            r_bit   <= r_bit + 6'd1;
                            r_shift <= r_shift << 1;
                            r_mosi  <= r_shift[C_CMD_BITS-2];
                        end
                    end
                end

                S_DATA: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        r_sck <= !r_sck;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_rise) begin
                        r_rx   <= {r_rx[5:0], spi_miso};
                        r_dbit <= r_dbit + 3'd1;
                        if (r_dbit == 3'd7) begin
                            r_remaining <= r_remaining - 16'd1;
                        end
                    end
                    // r_dbit wraps to 0 only after the 8th rise of a byte.
                    if (w_fall && (r_dbit == 3'd0)) begin
                        if (r_remaining == 16'd0) begin
                            r_state <= S_CS_HOLD;
                        end else if (r_tvalid && !m_axis_tready) begin
                            r_state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    r_cnt <= '0;
                    if (w_out_free) begin
                        r_state <= S_DATA;
                    end
                end

                S_CS_HOLD: begin
                    if (!r_csn) begin
                        if (w_out_free) begin
                            r_csn <= 1'b1;
                            r_cnt <= '0;
                        end
                    end else if (r_cnt == C_HOLD_LAST) begin
                        r_busy   <= 1'b0;
                        r_tready <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output register; a new byte is only loaded once the previous one left.
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= 8'd0;
        end else begin
            if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= {r_rx, spi_miso};
                r_tlast  <= (r_remaining == 16'd1);
            end
        end
    end

    assign s_cmd_tready  = r_tready;
    assign busy          = r_busy;
    assign spi_csn       = r_csn;
    assign spi_sck       = r_sck;
    assign spi_mosi      = r_mosi;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tdata  = r_tdata;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_reader
// Brief    : Self-checking bench: behavioural SPI NOR flash plus AXIS scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_reader;
    localparam int CLK_DIV = 2;
    localparam int PER     = 10;
`ifdef SPI_FLASH_READER_FAST_READ_EN
    localparam logic [7:0] C_OPCODE   = 8'h0B;
    localparam int         C_CMD_BITS = 40;
`else
    localparam logic [7:0] C_OPCODE   = 8'h03;
    localparam int         C_CMD_BITS = 32;
`endif

    logic        clk = 1'b0;
    logic        sresetn = 1'b0;
    logic        s_cmd_tready;
    logic        s_cmd_tvalid = 1'b0;
    logic [23:0] s_cmd_addr = '0;
    logic [15:0] s_cmd_len = '0;
    logic        m_axis_tready;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tdata;
    logic        busy;
    logic        spi_csn;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    spi_flash_reader #(.CLK_DIV(CLK_DIV)) dut (
        .clk           (clk),
        .sresetn       (sresetn),
        .s_cmd_tready  (s_cmd_tready),
        .s_cmd_tvalid  (s_cmd_tvalid),
        .s_cmd_addr    (s_cmd_addr),
        .s_cmd_len     (s_cmd_len),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .busy          (busy),
        .spi_csn       (spi_csn),
        .spi_sck       (spi_sck),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso)
    );

    initial forever #(PER / 2) clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Flash contents: explicit overrides, otherwise a fixed scramble of the address.
    logic [7:0] mem [logic [23:0]];
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return (a[7:0] * 8'd37) ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'hC3;
    endfunction

    logic [8:0]  exp_q [$];
    logic [23:0] frame_q [$];

    // ---------------- behavioural flash, SPI mode 0 ----------------
    int          rise_n = 0;
    logic [31:0] cmd_w = '0;
    logic [7:0]  dummy_w = '0;
    bit          in_frame = 0, had_frame = 0;
    time         t_cs_fall = 0, t_cs_rise = 0, t_last_rise = 0, t_accept = 0;
    time         per_min = '1, per_max = 0;
    int          n_frames = 0, n_extra_frames = 0;
    int          n_setup_err = 0, n_high_err = 0, n_low_err = 0, n_csn_hi_err = 0, n_acc_err = 0;
    int          fd;
    logic [23:0] fa;
    logic [7:0]  fb;

    always @(negedge spi_csn) begin
        in_frame  = 1;
        rise_n    = 0;
        cmd_w     = '0;
        dummy_w   = '0;
        per_min   = '1;
        per_max   = 0;
        t_cs_fall = $time;
        if (had_frame && ($time - t_cs_rise) < time'(2 * CLK_DIV * PER)) n_csn_hi_err++;
        if (($time - t_accept) != time'(PER)) n_acc_err++;
    end

    always @(posedge spi_sck) begin
        if (!spi_csn && sresetn) begin
            if (rise_n == 0) begin
                if (($time - t_cs_fall) != time'(CLK_DIV * PER)) n_setup_err++;
            end else begin
                if (($time - t_last_rise) < time'(2 * CLK_DIV * PER)) n_low_err++;
                if (($time - t_last_rise) < per_min) per_min = $time - t_last_rise;
                if (($time - t_last_rise) > per_max) per_max = $time - t_last_rise;
            end
            t_last_rise = $time;
            if (rise_n < 32) cmd_w = {cmd_w[30:0], spi_mosi};
            else if (rise_n < C_CMD_BITS) dummy_w = {dummy_w[6:0], spi_mosi};
            rise_n++;
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_csn && sresetn) begin
            if (($time - t_last_rise) != time'(CLK_DIV * PER)) n_high_err++;
            if (rise_n >= C_CMD_BITS) begin
                fd = rise_n - C_CMD_BITS;
                fa = cmd_w[23:0] + 24'(fd / 8);
                fb = flash_byte(fa);
                spi_miso = fb[7 - (fd % 8)];
            end
        end
    end

    always @(posedge spi_csn) begin
        if (in_frame) begin
            in_frame  = 0;
            had_frame = 1;
            t_cs_rise = $time;
            n_frames++;
            if (frame_q.size() == 0) begin
                n_extra_frames++;
            end else begin
                fa = frame_q.pop_front();
                check("opcode", {24'd0, cmd_w[31:24]}, {24'd0, C_OPCODE});
                check("addr", {8'd0, cmd_w[23:0]}, {8'd0, fa});
                if (C_CMD_BITS > 32) check("dummy_mosi", {24'd0, dummy_w}, 32'd0);
            end
        end
    end

    // ---------------- downstream ready and AXIS scoreboard ----------------
    int rdy_mode = 1;  // 0: hold low, 1: always high, 2: random
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    int         n_beats = 0, n_extra = 0, n_stable_err = 0;
    logic       p_v = 0, p_r = 0, p_l = 0;
    logic [7:0] p_d = 0;
    logic [8:0] e_beat;
    always @(negedge clk) begin
        if (!sresetn) begin
            p_v = 0;
        end else begin
            if (p_v && !p_r && (!m_axis_tvalid || m_axis_tdata !== p_d || m_axis_tlast !== p_l))
                n_stable_err++;
            if (m_axis_tvalid && m_axis_tready) begin
                n_beats++;
                if (exp_q.size() == 0) begin
                    n_extra++;
                end else begin
                    e_beat = exp_q.pop_front();
                    check("beat_data", {24'd0, m_axis_tdata}, {24'd0, e_beat[7:0]});
                    check("beat_last", {31'd0, m_axis_tlast}, {31'd0, e_beat[8]});
                end
            end
            p_v = m_axis_tvalid;
            p_r = m_axis_tready;
            p_d = m_axis_tdata;
            p_l = m_axis_tlast;
        end
    end

    task automatic send_cmd(input logic [23:0] a, input logic [15:0] l);
        int          t;
        logic [23:0] ba;
        t = 0;
        @(negedge clk);
        s_cmd_addr   = a;
        s_cmd_len    = l;
        s_cmd_tvalid = 1'b1;
        while (!s_cmd_tready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("cmd_tready", {31'd0, s_cmd_tready}, 32'd1);
        @(posedge clk);
        t_accept = $time;
        #1;
        s_cmd_tvalid = 1'b0;
        if (l != 16'd0) begin
            frame_q.push_back(a);
            for (int i = 0; i < int'(l); i++) begin
                ba = a + 24'(i);
                exp_q.push_back({(i == int'(l) - 1), flash_byte(ba)});
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0 || !s_cmd_tready) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_beats_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        #(PER * 90000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int          t, r0, nb0, f0, busy_seen;
        logic [23:0] ra;
        logic [15:0] rl;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tready", {31'd0, s_cmd_tready}, 32'd0);
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_csn", {31'd0, spi_csn}, 32'd1);
        check("rst_sck", {31'd0, spi_sck}, 32'd0);
        check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        sresetn = 1'b1;
        #1 check("tready_before_edge", {31'd0, s_cmd_tready}, 32'd0);
        @(negedge clk);
        check("tready_after_edge", {31'd0, s_cmd_tready}, 32'd1);

        // Directed read at full rate
        for (int i = 0; i < 4; i++) mem[24'h012345 + 24'(i)] = 8'hA0 + 8'(i);
        rdy_mode = 1;
        send_cmd(24'h012345, 16'd4);
        wait_idle();
        check("sck_period_min", 32'(per_min), 32'(2 * CLK_DIV * PER));
        check("sck_period_max", 32'(per_max), 32'(2 * CLK_DIV * PER));

        // Downstream stall after the first beat
        rdy_mode = 0;
        send_cmd(24'h012345, 16'd4);
        t = 0;
        while (!m_axis_tvalid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("stall_first_valid", {31'd0, m_axis_tvalid}, 32'd1);
        repeat (10) @(negedge clk);
        r0 = rise_n;
        repeat (90) @(negedge clk);
        check("stall_sck_rises", rise_n - r0, 32'd0);
        check("stall_sck_low", {31'd0, spi_sck}, 32'd0);
        check("stall_csn_low", {31'd0, spi_csn}, 32'd0);
        check("stall_hold_data", {24'd0, m_axis_tdata}, {24'd0, flash_byte(24'h012345)});
        rdy_mode = 1;
        wait_idle();

        // Zero-length command
        f0 = n_frames;
        nb0 = n_beats;
        send_cmd(24'h000100, 16'd0);
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
        end
        check("len0_busy", busy_seen, 32'd0);
        check("len0_frames", n_frames, f0);
        check("len0_beats", n_beats, nb0);
        check("len0_tready", {31'd0, s_cmd_tready}, 32'd1);

        // Reset during the second data byte
        nb0 = n_beats;
        send_cmd(24'h0ABCDE, 16'd4);
        t = 0;
        while (n_beats == nb0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("abort_first_beat", n_beats, nb0 + 1);
        repeat (3) @(posedge clk);
        #3;
        sresetn = 1'b0;
        #1;
        check("abort_csn", {31'd0, spi_csn}, 32'd1);
        check("abort_sck", {31'd0, spi_sck}, 32'd0);
        check("abort_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        sresetn = 1'b1;
        @(negedge clk);
        send_cmd(24'h054321, 16'd3);
        wait_idle();

        // Back-to-back commands
        f0 = n_frames;
        send_cmd(24'h000000, 16'd1);
        send_cmd(24'h100000, 16'd2);
        wait_idle();
        check("b2b_frames", n_frames, f0 + 2);

        // Randomized commands with random back-pressure
        for (int i = 0; i < 12; i++) begin
            ra = (i == 0) ? 24'hFFFFFE : 24'($urandom());
            rl = 16'($urandom_range(1, 5));
            rdy_mode = $urandom_range(1, 2);
            send_cmd(ra, rl);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();

        check("axis_stable", n_stable_err, 32'd0);
        check("sck_high_time", n_high_err, 32'd0);
        check("sck_low_time", n_low_err, 32'd0);
        check("cs_setup_time", n_setup_err, 32'd0);
        check("cs_high_time", n_csn_hi_err, 32'd0);
        check("csn_after_accept", n_acc_err, 32'd0);
        check("extra_beats", n_extra, 32'd0);
        check("extra_frames", n_extra_frames, 32'd0);
        check("frames_left", frame_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
